dircc_node_msg_rx_writer: RTL
=============================

DIRCC_NODE_MSG_RX_WRITER -- requirements
Module: dircc_node_msg_rx_writer

Interface
REQ-001 Parameter BASE_ADDR, default 14'h2000: halfword base address of the receive ring in processing memory port s2.
REQ-002 Parameter SLOTS, default 16, power of two: number of ring slots.
REQ-003 Parameter SLOT_WORDS, default 32, power of two: 16-bit words per slot (word 0 = header).
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 in_valid/in_ready/in_sop/in_eop  in/out/in/in  1 each  NoC message stream handshake; a word transfers when in_valid & in_ready.
REQ-007 in_data  in  16  message payload word.
REQ-008 mem_address  out  14  halfword address to s2.
REQ-009 mem_writedata  out  16  data to s2.
REQ-010 mem_byteenable/mem_chipselect/mem_write/mem_clken  out  2/1/1/1  s2 controls; byteenable and clken are constant all-ones.
REQ-011 csr_address  in  2  CSR select: 0 STATUS, 1 POP, 2 CTRL, 3 DROPS.
REQ-012 csr_read/csr_write  in  1 each  CSR strobes.
REQ-013 csr_writedata/csr_readdata  in/out  32 each  CSR data; readdata valid one cycle after csr_read.
REQ-014 irq  out  1  = irq_en & (count != 0), registered.

Function
REQ-015 FSM states IDLE, WRITE, DROP, COMMIT; reset state IDLE.
REQ-016 IDLE: in_ready=1; accepted word without in_sop is discarded; sop word with count==SLOTS -> DROP, else written at slot offset 1 -> WRITE (or COMMIT if in_eop).
REQ-017 WRITE: in_ready=1; each accepted word goes to next offset; offsets >= SLOT_WORDS are not written and set trunc flag; in_eop -> COMMIT.
REQ-018 Mid-message in_sop in WRITE: current slot abandoned uncommitted, word taken as offset 1 of a fresh message in the same slot.
REQ-019 DROP: in_ready=1, words consumed without memory writes until in_eop -> IDLE; drop counter +1 (16-bit, saturating at 16'hFFFF).
REQ-020 COMMIT (one cycle): in_ready=0; writes header {trunc, len[14:0]} at offset 0, len = words received (not words stored); wr_slot += 1 mod SLOTS; count += 1; -> IDLE.
REQ-021 Write address = BASE_ADDR + wr_slot*SLOT_WORDS + offset, 14-bit wrap-around.
REQ-022 Memory write latency: word accepted in cycle N appears on mem_write/mem_address/mem_writedata in cycle N+1, one cycle wide; mem_chipselect = mem_write.
REQ-023 POP write: if count != 0, rd_slot += 1 mod SLOTS, count -= 1; ignored when count == 0.
REQ-024 COMMIT and POP in same cycle: count unchanged, both pointers advance.
REQ-025 STATUS read = {count[7:0], rd_slot[7:0], wr_slot[7:0], 5'b0, state[2:0]}; CTRL bit0 irq_en (r/w), bit1 write-1 flush (rd_slot=wr_slot, count=0; in-flight message continues).

Reset
REQ-026 On reset_n low at a clock edge: state IDLE, pointers/count/drops 0, irq_en 0, in_ready 0 during reset then 1, mem_write 0, csr_readdata 0, irq 0.
REQ-027 Reset mid-message: partial slot discarded, no header written.

Configuration
REQ-028 DIRCC_RX_DROP_CNT_EN defined: drop counter implemented, DROPS reads {16'b0, drops}, write clears it.
REQ-029 DIRCC_RX_DROP_CNT_EN undefined: no counter logic; DROPS reads 0, writes ignored; dropping behaviour otherwise identical.

Structure
REQ-030 Package dircc_rx_pkg holds FSM state enum, CSR address constants, header field widths.
REQ-031 Sub-module dircc_rx_csr holds CSR decode, irq_en, readdata register and drop counter; FSM and address generation in top.

Verification
REQ-032 3-word message 0xA1,0xA2,0xA3 (BASE=0x2000) -> writes 0x2001..0x2003, then header 0x0003 at 0x2000; count=1, irq=1 if irq_en.
REQ-033 40-word message, SLOT_WORDS=32 -> offsets 1..31 written, header 0x8028; no write to next slot.
REQ-034 17 messages with no POP, SLOTS=16 -> 17th dropped, no mem_write, DROPS=1 (macro on) / 0 (macro off).
REQ-035 POP in COMMIT cycle with count=4 -> count stays 4, rd_slot and wr_slot both +1.
REQ-036 reset_n low after 2 words of a message -> no header written, STATUS=0, next message lands at slot 0.
REQ-037 Slot 15 commit -> wr_slot wraps to 0; following message writes from BASE_ADDR+1.

Source files
------------

// File: rtl/dircc_rx_pkg.sv
// Shared types and constants for the NoC receive-ring writer.
package dircc_rx_pkg;

  // FSM state; the encoding is visible in the STATUS register low bits.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWrite  = 3'd1,
    StDrop   = 3'd2,
    StCommit = 3'd3
  } rx_state_e;

  // CSR word addresses.
  localparam logic [1:0] CsrStatus = 2'd0;
  localparam logic [1:0] CsrPop    = 2'd1;
  localparam logic [1:0] CsrCtrl   = 2'd2;
  localparam logic [1:0] CsrDrops  = 2'd3;

  // Slot header layout: {trunc, len}.
  localparam int unsigned HdrLenW = 15;
  localparam int unsigned HdrW    = HdrLenW + 1;

  function automatic logic [HdrW-1:0] make_header(input logic trunc,
                                                  input logic [HdrLenW-1:0] len);
    return {trunc, len};
  endfunction

endpackage

// File: rtl/dircc_rx_csr.sv
// CSR block for the receive-ring writer: decode, irq enable, read register and
// optional drop counter (enabled by DIRCC_RX_DROP_CNT_EN).
module dircc_rx_csr
  import dircc_rx_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [1:0]  csr_address_i,
  input  logic        csr_read_i,
  input  logic        csr_write_i,
  input  logic [31:0] csr_writedata_i,
  output logic [31:0] csr_readdata_o,
  input  logic [2:0]  state_i,
  input  logic [7:0]  count_i,
  input  logic [7:0]  rd_slot_i,
  input  logic [7:0]  wr_slot_i,
  input  logic        drop_i,
  output logic        irq_en_o,
  output logic        pop_o,
  output logic        flush_o
);

  logic        irq_en_q;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] drops_rd;

  assign pop_o    = csr_write_i & (csr_address_i == CsrPop);
  assign flush_o  = csr_write_i & (csr_address_i == CsrCtrl) & csr_writedata_i[1];
  assign irq_en_o = irq_en_q;
  assign csr_readdata_o = rdata_q;

  logic unused_wdata;
  assign unused_wdata = ^csr_writedata_i[31:2];

`ifdef DIRCC_RX_DROP_CNT_EN
  logic [15:0] drops_q;

  // Saturating count of dropped messages; a DROPS write clears it.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      drops_q <= '0;
    end else if (csr_write_i && (csr_address_i == CsrDrops)) begin
      drops_q <= '0;
    end else if (drop_i && (drops_q != 16'hFFFF)) begin
      drops_q <= drops_q + 16'd1;
    end
  end

  assign drops_rd = {16'b0, drops_q};
`else
  logic unused_drop;
  assign unused_drop = drop_i;
  assign drops_rd    = '0;
`endif

  // Read mux.
  always_comb begin
    rdata_d = '0;
    unique case (csr_address_i)
      CsrStatus: rdata_d = {count_i, rd_slot_i, wr_slot_i, 5'b0, state_i};
      CsrPop:    rdata_d = '0;
      CsrCtrl:   rdata_d = {31'b0, irq_en_q};
      CsrDrops:  rdata_d = drops_rd;
      default:   rdata_d = '0;
    endcase
  end

  // irq enable and the read-data register (valid the cycle after csr_read).
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      irq_en_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (csr_write_i && (csr_address_i == CsrCtrl)) irq_en_q <= csr_writedata_i[0];
      if (csr_read_i) rdata_q <= rdata_d;
    end
  end

endmodule

// File: rtl/dircc_node_msg_rx_writer.sv
// Receive-ring writer: stores NoC messages into fixed-size slots of port s2,
// with a header word {trunc, len} written once the message is complete.
// Optional drop counter: define DIRCC_RX_DROP_CNT_EN.
module dircc_node_msg_rx_writer
  import dircc_rx_pkg::*;
#(
  parameter logic [13:0] BASE_ADDR  = 14'h2000,
  parameter int unsigned SLOTS      = 16,
  parameter int unsigned SLOT_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic [15:0] in_data,
  output logic [13:0] mem_address,
  output logic [15:0] mem_writedata,
  output logic [1:0]  mem_byteenable,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic        mem_clken,
  input  logic [1:0]  csr_address,
  input  logic        csr_read,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata,
  output logic        irq
);

  localparam int unsigned PtrW = $clog2(SLOTS);
  localparam int unsigned CntW = PtrW + 1;

  rx_state_e            state_q, state_d;
  logic [HdrLenW-1:0]   len_q, len_d;
  logic                 trunc_q, trunc_d;
  logic [PtrW-1:0]      wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 in_ready_q, mem_write_q, irq_q;
  logic [13:0]          mem_address_q;
  logic [15:0]          mem_writedata_q;

  logic        fire, do_write, commit, drop_pulse;
  logic [13:0] wr_off;
  logic        pop, pop_ok, flush, irq_en;
  logic [2:0]  state_bits;

  assign fire = in_valid & in_ready_q;
  assign pop_ok = pop & (count_q != '0);
  assign state_bits = state_q;

  function automatic logic [13:0] slot_addr(input logic [PtrW-1:0] slot,
                                            input logic [13:0] off);
    return BASE_ADDR + 14'(slot) * 14'(SLOT_WORDS) + off;
  endfunction

  // Message FSM next state: which word gets written where, and when to commit.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    trunc_d    = trunc_q;
    do_write   = 1'b0;
    wr_off     = '0;
    commit     = 1'b0;
    drop_pulse = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fire && in_sop) begin
          if (count_q == CntW'(SLOTS)) begin
            // Ring full: a single-word message is dropped on the spot.
            if (in_eop) drop_pulse = 1'b1;
            else        state_d    = StDrop;
          end else begin
            len_d    = 15'd1;
            trunc_d  = 1'b0;
            do_write = 1'b1;
            wr_off   = 14'd1;
            state_d  = in_eop ? StCommit : StWrite;
          end
        end
      end
      StWrite: begin
        if (fire) begin
          if (in_sop) begin
            // Restart in the same slot; the partial message is never committed.
            len_d    = 15'd1;
            trunc_d  = 1'b0;
            do_write = 1'b1;
            wr_off   = 14'd1;
          end else begin
            len_d = len_q + 15'd1;
            if (len_d < HdrLenW'(SLOT_WORDS)) begin
              do_write = 1'b1;
              wr_off   = len_d[13:0];
            end else begin
              trunc_d = 1'b1;
            end
          end
          if (in_eop) state_d = StCommit;
        end
      end
      StDrop: begin
        if (fire && in_eop) begin
          drop_pulse = 1'b1;
          state_d    = StIdle;
        end
      end
      StCommit: begin
        commit  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Ring pointers and occupancy; flush empties the ring but keeps the writer going.
  always_comb begin
    wr_slot_d = wr_slot_q + PtrW'(commit);
    rd_slot_d = rd_slot_q + PtrW'(pop_ok);
    count_d   = count_q + CntW'(commit) - CntW'(pop_ok);
    if (flush) begin
      rd_slot_d = wr_slot_d;
      count_d   = '0;
    end
  end

  // FSM state with registered handshake, memory-port and irq outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      len_q           <= '0;
      trunc_q         <= 1'b0;
      in_ready_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      irq_q           <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      trunc_q     <= trunc_d;
      in_ready_q  <= (state_d != StCommit);
      mem_write_q <= do_write | commit;
      if (commit) begin
        mem_address_q   <= slot_addr(wr_slot_q, 14'd0);
        mem_writedata_q <= make_header(trunc_q, len_q);
      end else if (do_write) begin
        mem_address_q   <= slot_addr(wr_slot_q, wr_off);
        mem_writedata_q <= in_data;
      end
      irq_q <= irq_en & (count_q != '0);
    end
  end

  // Ring pointer registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_slot_q <= '0;
      rd_slot_q <= '0;
      count_q   <= '0;
    end else begin
      wr_slot_q <= wr_slot_d;
      rd_slot_q <= rd_slot_d;
      count_q   <= count_d;
    end
  end

  dircc_rx_csr u_csr (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .csr_address_i  (csr_address),
    .csr_read_i     (csr_read),
    .csr_write_i    (csr_write),
    .csr_writedata_i(csr_writedata),
    .csr_readdata_o (csr_readdata),
    .state_i        (state_bits),
    .count_i        (8'(count_q)),
    .rd_slot_i      (8'(rd_slot_q)),
    .wr_slot_i      (8'(wr_slot_q)),
    .drop_i         (drop_pulse),
    .irq_en_o       (irq_en),
    .pop_o          (pop),
    .flush_o        (flush)
  );

  assign in_ready       = in_ready_q;
  assign mem_write      = mem_write_q;
  assign mem_chipselect = mem_write_q;
  assign mem_address    = mem_address_q;
  assign mem_writedata  = mem_writedata_q;
  assign mem_byteenable = 2'b11;
  assign mem_clken      = 1'b1;
  assign irq            = irq_q;

endmodule
